// File: rtl/axil_pkg.sv
// Shared AXI4-Lite helpers for the W-channel buffer (and the future R-channel
// block): strobe-width helper, byte-masking function, NULL counter width.
// Contents:
//   MAX_DATA_W / MAX_STRB_W : widest supported data path (64 bits / 8 strobes)
//   NULL_CNT_W              : width of the zero-strobe beat counter
//   STRB_W(dw)              : number of byte strobes for a data width
//   mask_bytes(d, s, zm)    : per-byte strobe masking at the widest data path
package axil_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;
    localparam int NULL_CNT_W = 8;

    function automatic int STRB_W(input int data_width);
        return data_width / 8;
    endfunction

    // Works at the widest data path; callers zero-extend their inputs and
    // truncate the result to their own width. Each byte is independent.
    function automatic logic [MAX_DATA_W-1:0] mask_bytes(
        input logic [MAX_DATA_W-1:0] data,
        input logic [MAX_STRB_W-1:0] strb,
        input logic                  zero_masked
    );
        logic [MAX_DATA_W-1:0] res;
        for (int i = 0; i < MAX_STRB_W; i++) begin
            res[8*i +: 8] = (strb[i] || !zero_masked) ? data[8*i +: 8] : 8'h00;
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with registered flags.
// Ports:
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_push, i_data    : write request (ignored when full) and write data
//   i_pop             : read request (ignored when empty)
//   o_data            : entry at the read pointer
//   o_not_full        : registered (count < DEPTH), 0 while in reset
//   o_not_empty       : registered (count != 0)
//   o_count           : occupancy 0..DEPTH
// Storage is not reset; only pointers, count and flags are.
module axil_sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_not_full,
    output logic                   o_not_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_not_full;
    logic             r_not_empty;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && r_not_full;
    assign w_pop  = i_pop && r_not_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Flags are derived from the next count so they are registered yet
    // exact in the cycle after every push/pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_not_full  <= 1'b0;
            r_not_empty <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count     <= w_count_next;
            r_not_full  <= (w_count_next < DEPTH_C);
            r_not_empty <= (w_count_next != '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data      = r_mem[r_rd_ptr];
    assign o_not_full  = r_not_full;
    assign o_not_empty = r_not_empty;
    assign o_count     = r_count;

endmodule

// File: rtl/axil_wdata_fifo.sv
// AXI4-Lite W-channel buffer: masks write data by WSTRB, queues beats in a
// DEPTH-entry FIFO, and counts zero-strobe beats for debug.
// Ports:
//   ACLK, ARESET                    : clock, asynchronous active-high reset
//   S_WVALID/S_WREADY/S_WDATA/S_WSTRB : upstream W beat
//   M_WVALID/M_WREADY/M_WDATA/M_WSTRB : downstream W beat (head of FIFO)
//   LEVEL                           : FIFO occupancy 0..DEPTH
//   NULL_CNT, NULL_CLR              : saturating zero-strobe beat count, clear
module axil_wdata_fifo
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter bit ZERO_MASKED = 1'b1
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          S_WVALID,
    output logic                          S_WREADY,
    input  logic [DATA_WIDTH-1:0]         S_WDATA,
    input  logic [STRB_W(DATA_WIDTH)-1:0] S_WSTRB,
    output logic                          M_WVALID,
    input  logic                          M_WREADY,
    output logic [DATA_WIDTH-1:0]         M_WDATA,
    output logic [STRB_W(DATA_WIDTH)-1:0] M_WSTRB,
    output logic [$clog2(DEPTH):0]        LEVEL,
    output logic [NULL_CNT_W-1:0]         NULL_CNT,
    input  logic                          NULL_CLR
);
    localparam int SW      = STRB_W(DATA_WIDTH);
    localparam int ENTRY_W = DATA_WIDTH + SW;

    logic [DATA_WIDTH-1:0] w_wdata_masked;
    logic [ENTRY_W-1:0]    w_entry_in;
    logic [ENTRY_W-1:0]    w_entry_out;
    logic                  w_not_full;
    logic                  w_not_empty;
    logic                  w_push;
    logic                  w_null_beat;
    logic [NULL_CNT_W-1:0] r_null_cnt;

    assign w_wdata_masked = DATA_WIDTH'(mask_bytes(MAX_DATA_W'(S_WDATA),
                                                   MAX_STRB_W'(S_WSTRB),
                                                   ZERO_MASKED));
    assign w_entry_in = {S_WSTRB, w_wdata_masked};

    axil_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (ACLK),
        .i_rst       (ARESET),
        .i_push      (S_WVALID),
        .i_data      (w_entry_in),
        .i_pop       (M_WREADY),
        .o_data      (w_entry_out),
        .o_not_full  (w_not_full),
        .o_not_empty (w_not_empty),
        .o_count     (LEVEL)
    );

    assign S_WREADY = w_not_full;
    assign M_WVALID = w_not_empty;
    assign M_WDATA  = w_entry_out[DATA_WIDTH-1:0];
    assign M_WSTRB  = w_entry_out[ENTRY_W-1 -: SW];

    assign w_push      = S_WVALID && w_not_full;
    assign w_null_beat = w_push && (S_WSTRB == '0);

    // Clear has priority over a coincident increment.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_null_cnt <= '0;
        end else if (NULL_CLR) begin
            r_null_cnt <= '0;
        end else if (w_null_beat && (r_null_cnt != '1)) begin
            r_null_cnt <= r_null_cnt + NULL_CNT_W'(1);
        end
    end

    assign NULL_CNT = r_null_cnt;

endmodule

// File: tb/tb_axil_wdata_fifo.sv
// Directed self-checking bench for axil_wdata_fifo (DATA_WIDTH=32, DEPTH=4).
// A second instance with ZERO_MASKED=0 shares the stimulus to check raw data.
module tb_axil_wdata_fifo;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        S_WVALID;
    logic [31:0] S_WDATA;
    logic [3:0]  S_WSTRB;
    logic        M_WREADY;
    logic        NULL_CLR;

    logic        S_WREADY, M_WVALID;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic [2:0]  LEVEL;
    logic [7:0]  NULL_CNT;

    logic        raw_s_wready, raw_m_wvalid;
    logic [31:0] raw_m_wdata;
    logic [3:0]  raw_m_wstrb;
    logic [2:0]  raw_level;
    logic [7:0]  raw_null_cnt;

    int n_chk = 0;
    int n_bad = 0;

    always #5 ACLK = ~ACLK;

    axil_wdata_fifo #(.DATA_WIDTH(32), .DEPTH(4), .ZERO_MASKED(1'b1)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
        .LEVEL(LEVEL), .NULL_CNT(NULL_CNT), .NULL_CLR(NULL_CLR)
    );

    axil_wdata_fifo #(.DATA_WIDTH(32), .DEPTH(4), .ZERO_MASKED(1'b0)) dut_raw (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_WVALID(S_WVALID), .S_WREADY(raw_s_wready), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
        .M_WVALID(raw_m_wvalid), .M_WREADY(M_WREADY), .M_WDATA(raw_m_wdata), .M_WSTRB(raw_m_wstrb),
        .LEVEL(raw_level), .NULL_CNT(raw_null_cnt), .NULL_CLR(NULL_CLR)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARESET   = 1'b1;
        S_WVALID = 1'b0;
        S_WDATA  = 32'h0;
        S_WSTRB  = 4'h0;
        M_WREADY = 1'b0;
        NULL_CLR = 1'b0;

        // reset values
        tick();
        chk("rst_wready", 32'(S_WREADY), 32'h0);
        chk("rst_mvalid", 32'(M_WVALID), 32'h0);
        chk("rst_level",  32'(LEVEL),    32'h0);
        chk("rst_nullcnt", 32'(NULL_CNT), 32'h0);
        tick();
        chk("rst_wready_hold", 32'(S_WREADY), 32'h0);
        ARESET = 1'b0;
        tick();
        chk("post_rst_wready", 32'(S_WREADY), 32'h1);
        chk("post_rst_mvalid", 32'(M_WVALID), 32'h0);

        // single masked beat
        S_WVALID = 1'b1; S_WDATA = 32'hDEADBEEF; S_WSTRB = 4'b0101; M_WREADY = 1'b1;
        tick();
        S_WVALID = 1'b0;
        chk("single_mvalid", 32'(M_WVALID), 32'h1);
        chk("single_mdata",  M_WDATA,       32'h00AD00EF);
        chk("single_mstrb",  32'(M_WSTRB),  32'h5);
        chk("single_raw",    raw_m_wdata,   32'hDEADBEEF);
        chk("single_level",  32'(LEVEL),    32'h1);
        tick();
        chk("single_drain_mvalid", 32'(M_WVALID), 32'h0);
        chk("single_drain_level",  32'(LEVEL),    32'h0);

        // fill and backpressure
        M_WREADY = 1'b0; S_WVALID = 1'b1; S_WSTRB = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            S_WDATA = 32'(i);
            tick();
            chk("fill_level", 32'(LEVEL), 32'(i));
        end
        chk("full_wready", 32'(S_WREADY), 32'h0);
        S_WDATA = 32'h5;
        tick();
        chk("full_hold_level",  32'(LEVEL),    32'h4);
        chk("full_hold_wready", 32'(S_WREADY), 32'h0);
        chk("full_head",        M_WDATA,       32'h1);
        M_WREADY = 1'b1;
        tick();
        M_WREADY = 1'b0;
        chk("bp_pop_level",  32'(LEVEL),    32'h3);
        chk("bp_pop_wready", 32'(S_WREADY), 32'h1);
        chk("bp_pop_head",   M_WDATA,       32'h2);
        tick();
        S_WVALID = 1'b0;
        chk("bp_push5_level",  32'(LEVEL),    32'h4);
        chk("bp_push5_wready", 32'(S_WREADY), 32'h0);
        M_WREADY = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("drain_mvalid", 32'(M_WVALID), 32'h1);
            chk("drain_data",   M_WDATA,       32'(i));
            tick();
        end
        chk("drain_empty", 32'(M_WVALID), 32'h0);
        chk("drain_level", 32'(LEVEL),    32'h0);

        // streaming, 20 beats, pointers wrap 5 times
        S_WVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            S_WDATA = 32'h100 + 32'(i);
            tick();
            chk("stream_mvalid", 32'(M_WVALID), 32'h1);
            chk("stream_data",   M_WDATA,       32'h100 + 32'(i));
            chk("stream_level",  32'(LEVEL),    32'h1);
            chk("stream_wready", 32'(S_WREADY), 32'h1);
        end
        S_WVALID = 1'b0;
        tick();
        chk("stream_end_level", 32'(LEVEL), 32'h0);

        // simultaneous push/pop at LEVEL=2
        M_WREADY = 1'b0; S_WVALID = 1'b1;
        S_WDATA = 32'hA0; tick();
        S_WDATA = 32'hB0; tick();
        chk("pp_level2", 32'(LEVEL), 32'h2);
        M_WREADY = 1'b1;
        S_WDATA = 32'hC0; tick();
        chk("pp_level_a", 32'(LEVEL), 32'h2);
        chk("pp_head_a",  M_WDATA,    32'hB0);
        S_WDATA = 32'hD0; tick();
        chk("pp_level_b", 32'(LEVEL), 32'h2);
        chk("pp_head_b",  M_WDATA,    32'hC0);
        S_WVALID = 1'b0;
        tick();
        chk("pp_head_c", M_WDATA,    32'hD0);
        chk("pp_level_c", 32'(LEVEL), 32'h1);
        tick();
        chk("pp_empty", 32'(M_WVALID), 32'h0);

        // null strobes
        chk("null_start", 32'(NULL_CNT), 32'h0);
        S_WVALID = 1'b1; S_WSTRB = 4'h0;
        for (int i = 0; i < 3; i++) begin
            S_WDATA = 32'hAAAA0000 + 32'(i);
            tick();
            chk("null_fwd_valid", 32'(M_WVALID), 32'h1);
            chk("null_fwd_data",  M_WDATA,       32'h0);
            chk("null_fwd_strb",  32'(M_WSTRB),  32'h0);
            chk("null_fwd_raw",   raw_m_wdata,   32'hAAAA0000 + 32'(i));
        end
        chk("null_cnt3", 32'(NULL_CNT), 32'h3);
        NULL_CLR = 1'b1;
        tick();
        NULL_CLR = 1'b0;
        chk("null_clr_wins", 32'(NULL_CNT), 32'h0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 253) chk("null_cnt254", 32'(NULL_CNT), 32'd254);
            if (i == 254) chk("null_cnt255", 32'(NULL_CNT), 32'd255);
        end
        chk("null_sat", 32'(NULL_CNT), 32'd255);
        S_WVALID = 1'b0; S_WSTRB = 4'hF;
        tick();
        chk("null_drain", 32'(LEVEL), 32'h0);

        // mid-operation asynchronous reset
        M_WREADY = 1'b0; S_WVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            S_WDATA = 32'h500 + 32'(i);
            tick();
        end
        S_WVALID = 1'b0;
        chk("pre_rst_level",  32'(LEVEL),    32'h3);
        chk("pre_rst_mvalid", 32'(M_WVALID), 32'h1);
        #2;
        ARESET = 1'b1;
        #1;
        chk("async_rst_mvalid",  32'(M_WVALID), 32'h0);
        chk("async_rst_wready",  32'(S_WREADY), 32'h0);
        chk("async_rst_level",   32'(LEVEL),    32'h0);
        chk("async_rst_nullcnt", 32'(NULL_CNT), 32'h0);
        tick();
        ARESET = 1'b0;
        tick();
        chk("rerst_wready", 32'(S_WREADY), 32'h1);
        chk("rerst_mvalid", 32'(M_WVALID), 32'h0);
        S_WVALID = 1'b1; S_WDATA = 32'h77; S_WSTRB = 4'hF;
        tick();
        S_WVALID = 1'b0;
        chk("rerst_first_valid", 32'(M_WVALID), 32'h1);
        chk("rerst_first_data",  M_WDATA,       32'h77);
        chk("rerst_level",       32'(LEVEL),    32'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
